// File: rtl/fixed_to_float_pipe.sv
// Fixed-point (signed/unsigned, W bits, F fractional) to IEEE-754 binary32, round-to-nearest-even; 3-cycle latency.
// All three stages advance together on ~o_VALID | i_READY, so a stalled output freezes the whole pipe.
module fixed_to_float_pipe #(
   parameter int P_IN_WIDTH  = 32,
   parameter int P_FRAC_BITS = 0
) (
   input  logic                  i_CLK,
   input  logic                  i_RST_N,
   input  logic                  i_VALID,
   output logic                  o_READY,
   input  logic                  i_SIGNED,
   input  logic [P_IN_WIDTH-1:0] i_FIXED_WORD,
   output logic                  o_VALID,
   input  logic                  i_READY,
   output logic [31:0]           o_FLOAT_WORD,
   output logic                  o_ZERO,
   output logic                  o_INEXACT
);

   localparam int W        = P_IN_WIDTH;
   localparam int LZW      = $clog2(W);
   localparam int XW       = W + 23;
   localparam int EXP_BASE = 127 + W - 1 - P_FRAC_BITS;

   typedef struct packed {
      logic         sign;
      logic [W-1:0] mag;
   } s1_t;

   typedef struct packed {
      logic           sign;
      logic           zero;
      logic [LZW-1:0] lz;
      logic [W-2:0]   frac;
   } s2_t;

   logic           w_adv;
   logic           s1_vld, s2_vld;
   s1_t            s1_q;
   s2_t            s2_q;
   logic           sign_d;
   logic [W-1:0]   mag_d;
   logic [LZW-1:0] lz_d;
   logic [W-2:0]   frac_d;
   logic [XW-1:0]  ext;
   logic [22:0]    mant;
   logic           guard, sticky, round_up;
   logic [23:0]    mant_rnd;
   logic [7:0]     exp_b;
   logic [31:0]    float_d;
   logic           inexact_d;

   assign w_adv   = ~o_VALID | i_READY;
   assign o_READY = w_adv;

   // Most negative input negates to 2^(W-1), which still fits as an unsigned magnitude.
   assign sign_d = i_SIGNED & i_FIXED_WORD[W-1];
   assign mag_d  = sign_d ? -i_FIXED_WORD : i_FIXED_WORD;

   always_comb begin
      lz_d = '0;
      for (int i = 0; i < W; i++) begin
         if (s1_q.mag[i]) lz_d = LZW'(W - 1 - i);
      end
   end

   // The hidden one is dropped here; only the bits below it travel to stage 3.
   assign frac_d = (W-1)'(s1_q.mag << lz_d);

   // Padding with zeros makes narrow inputs fall out exact with no special case.
   assign ext      = {s2_q.frac, 24'b0};
   assign mant     = ext[XW-1 -: 23];
   assign guard    = ext[W-1];
   assign sticky   = |ext[W-2:0];
   assign round_up = guard & (sticky | mant[0]);
   assign mant_rnd = {1'b0, mant} + {23'b0, round_up};
   assign exp_b    = 8'(EXP_BASE) - 8'(s2_q.lz) + {7'b0, mant_rnd[23]};

   always_comb begin
      float_d   = {s2_q.sign, exp_b, mant_rnd[22:0]};
      inexact_d = guard | sticky;
      if (s2_q.zero) begin
         float_d   = 32'h0;
         inexact_d = 1'b0;
      end
   end

   always_ff @(posedge i_CLK) begin
      if (!i_RST_N) begin
         s1_vld       <= 1'b0;
         s2_vld       <= 1'b0;
         o_VALID      <= 1'b0;
         o_FLOAT_WORD <= '0;
         o_ZERO       <= 1'b0;
         o_INEXACT    <= 1'b0;
      end else if (w_adv) begin
         s1_vld       <= i_VALID;
         s1_q.sign    <= sign_d;
         s1_q.mag     <= mag_d;
         s2_vld       <= s1_vld;
         s2_q.sign    <= s1_q.sign;
         s2_q.zero    <= (s1_q.mag == '0);
         s2_q.lz      <= lz_d;
         s2_q.frac    <= frac_d;
         o_VALID      <= s2_vld;
         o_FLOAT_WORD <= float_d;
         o_ZERO       <= s2_q.zero;
         o_INEXACT    <= inexact_d;
      end
   end

endmodule

// File: tb/tb_fixed_to_float_pipe.sv
// Bench for fixed_to_float_pipe: four parameter variants driven in lockstep, checked against a queued scoreboard.
module tb_fixed_to_float_pipe;

   localparam int NI = 4;
   localparam int WS [NI] = '{32, 32, 8, 64};
   localparam int FS [NI] = '{0, 16, 8, 0};

   typedef struct packed {
      logic [31:0]           cyc;
      logic                  lat;
      logic [NI-1:0][33:0]   r;
   } ent_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 rst_n, in_vld, in_sgn, out_rdy;
   logic [63:0]          in_word;
   logic [NI-1:0]        rdy_o, vld_o, zr, ix;
   logic [NI-1:0][31:0]  fw;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      fixed_to_float_pipe #(.P_IN_WIDTH(WS[g]), .P_FRAC_BITS(FS[g])) u_dut (
         .i_CLK        (clk),
         .i_RST_N      (rst_n),
         .i_VALID      (in_vld),
         .o_READY      (rdy_o[g]),
         .i_SIGNED     (in_sgn),
         .i_FIXED_WORD (in_word[WS[g]-1:0]),
         .o_VALID      (vld_o[g]),
         .i_READY      (out_rdy),
         .o_FLOAT_WORD (fw[g]),
         .o_ZERO       (zr[g]),
         .o_INEXACT    (ix[g])
      );
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_chk++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
      end
   endtask

   // Reference: locate the top set bit, then round the discarded remainder against one half.
   function automatic logic [33:0] model(input logic [63:0] x, input logic sgn, input int w, input int f);
      logic [63:0] mask, m, q, rem, half;
      logic        neg, inx;
      int          p, e, sh;
      mask = (64'd1 << w) - 64'd1;
      m    = x & mask;
      neg  = sgn && m[w-1];
      if (neg) m = (~m + 64'd1) & mask;
      if (m == 64'd0) return {1'b1, 1'b0, 32'h0};
      p = 0;
      for (int i = 0; i < 64; i++) if (m[i]) p = i;
      e   = 127 + p - f;
      inx = 1'b0;
      if (p <= 23) begin
         q = m << (23 - p);
      end else begin
         sh   = p - 23;
         q    = m >> sh;
         rem  = m & ((64'd1 << sh) - 64'd1);
         half = 64'd1 << (sh - 1);
         inx  = (rem != 64'd0);
         if (rem > half || (rem == half && q[0])) q = q + 64'd1;
         if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
         end
      end
      return {1'b0, inx, neg, 8'(e), q[22:0]};
   endfunction

   ent_t        sbq[$];
   logic [31:0] cyc = 32'd0;
   logic        rst_q = 1'b1;
   logic        hold = 1'b0;
   logic [33:0] held = '0;
   logic        drv_lat = 1'b0;
   int          drv_ovr_idx = -1;
   logic [33:0] drv_ovr = '0;
   logic        rnd_rdy = 1'b0;

   always @(posedge clk) begin
      cyc   <= cyc + 32'd1;
      rst_q <= rst_n;
   end

   always @(negedge clk) begin : mon
      ent_t e;
      if (!rst_q) begin
         check("reset_o_valid", 64'(vld_o), 64'd0);
         check("reset_o_ready", 64'(rdy_o), 64'hF);
         for (int i = 0; i < NI; i++)
            check($sformatf("reset_outputs[%0d]", i), {30'd0, zr[i], ix[i], fw[i]}, 64'd0);
      end
      if (!rst_n) begin
         sbq.delete();
         hold = 1'b0;
      end else begin
         check("o_ready", 64'(rdy_o), (~vld_o[0] | out_rdy) ? 64'hF : 64'h0);
         if (hold) begin
            check("stall_o_valid", 64'(vld_o), 64'hF);
            check("stall_outputs", {30'd0, zr[0], ix[0], fw[0]}, {30'd0, held});
         end
         if (vld_o[0] && out_rdy) begin
            if (sbq.size() == 0) begin
               check("spurious_output", 64'(vld_o[0]), 64'd0);
            end else begin
               e = sbq.pop_front();
               for (int i = 0; i < NI; i++) begin
                  check($sformatf("valid[%0d]", i), 64'(vld_o[i]), 64'd1);
                  check($sformatf("float[%0d]", i), 64'(fw[i]), 64'(e.r[i][31:0]));
                  check($sformatf("zero[%0d]", i), 64'(zr[i]), 64'(e.r[i][33]));
                  check($sformatf("inexact[%0d]", i), 64'(ix[i]), 64'(e.r[i][32]));
               end
               if (e.lat) check("latency", 64'(cyc - e.cyc), 64'd3);
            end
         end
         if (in_vld && rdy_o[0]) begin
            e.cyc = cyc;
            e.lat = drv_lat;
            for (int i = 0; i < NI; i++) e.r[i] = model(in_word, in_sgn, WS[i], FS[i]);
            if (drv_ovr_idx >= 0) e.r[drv_ovr_idx] = drv_ovr;
            sbq.push_back(e);
         end
         hold = vld_o[0] & ~out_rdy;
         held = {zr[0], ix[0], fw[0]};
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rnd_rdy) out_rdy = ($urandom_range(0, 3) != 0);
   endtask

   task automatic idle(input int n);
      in_vld = 1'b0;
      repeat (n) tick();
   endtask

   // oi >= 0 replaces the model result for that instance with a hand-derived constant.
   task automatic send(input logic [63:0] w, input logic s, input logic lat, input int oi, input logic [33:0] ov);
      bit acc = 1'b0;
      int n   = 0;
      in_word     = w;
      in_sgn      = s;
      drv_lat     = lat;
      drv_ovr_idx = oi;
      drv_ovr     = ov;
      in_vld      = 1'b1;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = rdy_o[0];
         tick();
         n++;
      end
      if (!acc) check("send_timeout", 64'(acc), 64'd1);
      in_vld = 1'b0;
   endtask

   function automatic logic [63:0] rand_word();
      case ($urandom_range(0, 4))
         0:       return {$urandom, $urandom};
         1:       return 64'($urandom_range(0, 300));
         2:       return 64'd1 << $urandom_range(0, 63);
         3:       return (64'd1 << $urandom_range(1, 63)) - 64'($urandom_range(0, 3));
         default: return ~64'($urandom_range(0, 5));
      endcase
   endfunction

   initial begin
      int n;
      rst_n   = 1'b0;
      in_vld  = 1'b0;
      in_sgn  = 1'b0;
      in_word = '0;
      out_rdy = 1'b1;
      repeat (3) tick();
      rst_n = 1'b1;
      idle(2);

      // Hand-derived results, streamed back to back with latency checked on each.
      send(64'd1,                 1'b1, 1'b1, 0, {2'b00, 32'h3F800000});
      send(64'hFFFFFFFF,          1'b1, 1'b1, 0, {2'b00, 32'hBF800000});
      send(64'h80000000,          1'b1, 1'b1, 0, {2'b00, 32'hCF000000});
      send(64'd0,                 1'b0, 1'b1, 0, {2'b10, 32'h00000000});
      send(64'd0,                 1'b1, 1'b1, 0, {2'b10, 32'h00000000});
      send(64'd16777217,          1'b0, 1'b1, 0, {2'b01, 32'h4B800000});
      send(64'd16777219,          1'b0, 1'b1, 0, {2'b01, 32'h4B800002});
      send(64'd16777221,          1'b0, 1'b1, 0, {2'b01, 32'h4B800002});
      send(64'hFFFFFFFF,          1'b0, 1'b1, 0, {2'b01, 32'h4F800000});
      send(64'h00018000,          1'b1, 1'b1, 1, {2'b00, 32'h3FC00000});
      send(64'hFFFF0000,          1'b1, 1'b1, 1, {2'b00, 32'hBF800000});
      send(64'h01,                1'b0, 1'b1, 2, {2'b00, 32'h3B800000});
      send(64'h8000000000000000,  1'b0, 1'b1, 3, {2'b00, 32'h5F000000});
      idle(6);

      rnd_rdy = 1'b1;
      for (int k = 0; k < 150; k++) begin
         send(rand_word(), 1'($urandom_range(0, 1)), 1'b0, -1, 34'd0);
         if ($urandom_range(0, 9) < 3) idle($urandom_range(1, 2));
      end
      rnd_rdy = 1'b0;
      out_rdy = 1'b1;
      idle(8);

      // Eight-word burst with a five-cycle downstream stall in the middle.
      for (int k = 0; k < 4; k++) send(64'(32'hDEAD0000 + k * 32'h1357), 1'b1, 1'b0, -1, 34'd0);
      out_rdy = 1'b0;
      in_word = 64'(32'hDEAD0000 + 4 * 32'h1357);
      in_vld  = 1'b1;
      repeat (5) tick();
      out_rdy = 1'b1;
      for (int k = 4; k < 8; k++) send(64'(32'hDEAD0000 + k * 32'h1357), 1'b1, 1'b0, -1, 34'd0);
      idle(6);

      // Reset with three words in flight; none of them may emerge afterwards.
      for (int k = 0; k < 3; k++) send(64'(100 + k), 1'b0, 1'b1, -1, 34'd0);
      rst_n  = 1'b0;
      in_vld = 1'b0;
      tick();
      rst_n = 1'b1;
      idle(8);
      send(64'd5, 1'b0, 1'b1, 0, {2'b00, 32'h40A00000});
      idle(6);

      n = 0;
      while (sbq.size() != 0 && n < 100) begin
         tick();
         n++;
      end
      check("scoreboard_drained", 64'(sbq.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
